// File: rtl/bitserial_logic_unit_if.sv
// Request/response channel for the bit-serial logic unit: operands and opcode
// in, result and zero flag out, each side with a valid/ready handshake.
interface bitserial_logic_unit_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/bitserial_logic_unit.sv
// Bit-serial AND/OR/XOR/XNOR unit: one result bit per clock, LSB first,
// WIDTH cycles per transaction, full result held until the consumer takes it.
module bitserial_logic_unit #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    bitserial_logic_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bit_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        unique case (op_q)
            2'b00:   bit_f = a_sh_q[0] & b_sh_q[0];
            2'b01:   bit_f = a_sh_q[0] | b_sh_q[0];
            2'b10:   bit_f = a_sh_q[0] ^ b_sh_q[0];
            default: bit_f = ~(a_sh_q[0] ^ b_sh_q[0]);
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        op_d    = op_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    op_d    = bus.op;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // New bit enters at the MSB so after WIDTH shifts bit i lines up with operand bit i.
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {bit_f, res_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.zero      = (res_q == '0);
endmodule

// File: doc/bitserial_logic_unit.md
# bitserial_logic_unit

Bit-serial bitwise logic responder for the BinaryLogic group. Accepts two WIDTH-bit operands and an opcode over a valid/ready request channel, evaluates AND/OR/XOR/XNOR one bit per clock (LSB first), and returns the full result plus a zero flag over a valid/ready response channel. It is the responding end of the operand/result exchange that logic-gate benches drive, and it trades area for WIDTH-cycle latency.

## Interface
- WIDTH, 4, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- a  input  WIDTH  operand A, sampled on request handshake
- b  input  WIDTH  operand B, sampled on request handshake
- op  input  2  opcode, sampled on handshake: 00 AND, 01 OR, 10 XOR, 11 XNOR
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  WIDTH  computed result
- zero  output  1  result == 0

## Operation
- Request handshake: in_valid && in_ready on a rising edge. Response handshake: out_valid && out_ready on a rising edge.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On request handshake, capture a, b, op into internal shift registers, clear result register, clear bit counter to 0, go to SHIFT.
- SHIFT: in_ready=0, out_valid=0. Each cycle compute f(a_sh[0], b_sh[0]) per op; shift a_sh and b_sh right by one; shift result register right by one with the new bit entering at bit WIDTH-1; increment counter. When counter reaches WIDTH-1 (WIDTH-th bit processed), go to DONE.
- After WIDTH SHIFT cycles, result holds the full bitwise result, with bit i = f(a[i], b[i]).
- DONE: out_valid=1, result and zero are stable. Stay until response handshake, then go to IDLE.
- Changes on a, b, op outside the request handshake have no effect.
- in_valid asserted during SHIFT/DONE is ignored and is not queued; the requester holds it until in_ready.
- zero is combinational from the result register and is meaningful only while out_valid=1.
- Counter width is clog2(WIDTH)+1 bits; no wrap occurs within a transaction.

## Timing
- Reset (async assert, takes effect immediately): state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, counter=0, shift registers=0.
- Reset deassertion is synchronous to clk by the environment; the first request may handshake on the first edge after release.
- Reset during SHIFT or DONE aborts the transaction. No partial result is ever presented.
- Latency: request handshake at edge N gives out_valid=1 after edge N+WIDTH. For WIDTH=4, the request accepted at edge 0 produces out_valid high from edge 4.
- out_ready may be high before out_valid; the response handshake then occurs on the first DONE edge, so DONE lasts exactly one cycle.
- Throughput: at most one transaction per WIDTH+2 cycles (IDLE, WIDTH×SHIFT, DONE). in_ready returns high the cycle after the response handshake.
- There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Test plan
- XOR basic: a=1101, b=0111, op=10, out_ready=1 -> out_valid exactly 4 cycles after accept, result=1010, zero=0.
- XOR equal operands: a=1010, b=1010, op=10 -> result=0000, zero=1. Then op=11 with the same operands -> result=1111, zero=0.
- AND/OR sweep: a=1100, b=1010 -> AND=1000, OR=1110. Check bit i against f(a[i],b[i]) for all four ops with random operands over 200 transactions, WIDTH=4 and WIDTH=8.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> result, zero and out_valid stay stable, in_ready stays 0, and a new in_valid with different operands is not captured. Raise out_ready -> one handshake, then in_ready=1 on the next cycle.
- Reset mid-operation: assert rst two cycles into SHIFT -> in_ready=1, out_valid=0, result=0 immediately. After release, a fresh request a=0011, b=0101, op=00 -> result=0001.
- Back-to-back: keep in_valid and out_ready high with two queued requests -> second accept occurs exactly 1 cycle after the first response handshake; both results are correct and the interval is WIDTH+2 cycles.
